// File: rtl/seq_div_if.sv
// Start/busy/done handshake and result bus for seq_divider.
// SEQ_DIV_DZ_EN adds the div_by_zero flag.
interface seq_div_if #(
  parameter int WIDTH = 16
);
  // Handshake: start is sampled only while idle or done. busy is high while iterating.
  // done is high while the results are held, and the results are valid for as long as done is high.
  logic             start;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic [1:0]       state_dbg;
`ifdef SEQ_DIV_DZ_EN
  logic             div_by_zero;
`endif

  modport master (
    output start, operand1, operand2,
    input  busy, done, Quotient, Remainder, state_dbg
`ifdef SEQ_DIV_DZ_EN
    , input div_by_zero
`endif
  );

  modport slave (
    input  start, operand1, operand2,
    output busy, done, Quotient, Remainder, state_dbg
`ifdef SEQ_DIV_DZ_EN
    , output div_by_zero
`endif
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-and-subtract divider that produces one quotient bit per cycle.
// SEQ_DIV_DZ_EN short-circuits a zero divisor straight to DONE and flags it.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  seq_div_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             accept;
  logic             dz_hit;

`ifdef SEQ_DIV_DZ_EN
  assign dz_hit = (bus.operand2 == '0);
`else
  assign dz_hit = 1'b0;
`endif

  assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  // Trial subtraction: a clear borrow bit means the divisor fits, so keep the difference.
  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial   = r_shift - {1'b0, d_q};
  assign r_step  = trial[WIDTH] ? r_shift : trial;
  assign q_step  = {q_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          if (dz_hit) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = bus.operand1;
          end else begin
            state_d = S_RUN;
            d_d     = bus.operand2;
            q_d     = bus.operand1;
            r_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      S_RUN: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          quot_d  = q_step;
          rem_d   = r_step[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

`ifdef SEQ_DIV_DZ_EN
  logic dz_q, dz_d;
  assign dz_d = accept ? dz_hit : dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dz_q <= 1'b0;
    else        dz_q <= dz_d;
  end

  assign bus.div_by_zero = dz_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rem_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios followed by randomized operands
// checked against a plain integer division model.
module tb_seq_divider;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [15:0] last_q, last_r;
  logic [31:0] exp_q[$];

  seq_div_if #(.WIDTH(16)) bus ();

  seq_divider #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_DIV_DZ_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    int unsigned q, r;
    if (b == 0) begin
      q = 32'hFFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q[15:0], r[15:0]};
  endfunction

  // One division. If pulse_at is nonzero, an extra start (7/7) is raised before that RUN edge.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input int pulse_at,
                         input string tag);
    logic [31:0] e;
    bit fast;
    e    = model(a, b);
    fast = DZ_EN && (b == 0);
    bus.start = 1'b1; bus.operand1 = a; bus.operand2 = b;
    tick();
    bus.start = 1'b0;
    bus.operand1 = 16'($urandom); bus.operand2 = 16'($urandom);
    if (!fast) begin
      for (int k = 1; k <= 16; k++) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.Quotient !== last_q ||
            bus.Remainder !== last_r) begin
          failures++;
          $display("FAIL %s run_edge%0d: busy=%b done=%b q=%h r=%h required busy=1 done=0 q=%h r=%h",
                   tag, k - 1, bus.busy, bus.done, bus.Quotient, bus.Remainder, last_q, last_r);
        end
        if (k == pulse_at) begin
          bus.start = 1'b1; bus.operand1 = 16'd7; bus.operand2 = 16'd7;
        end
        tick();
        bus.start = 1'b0;
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.Quotient !== e[31:16] ||
        bus.Remainder !== e[15:0]) begin
      failures++;
      $display("FAIL %s result: done=%b busy=%b q=%h r=%h required done=1 busy=0 q=%h r=%h",
               tag, bus.done, bus.busy, bus.Quotient, bus.Remainder, e[31:16], e[15:0]);
    end
`ifdef SEQ_DIV_DZ_EN
    checks++;
    if (bus.div_by_zero !== (b == 0)) begin
      failures++;
      $display("FAIL %s dz_flag: got %b required %b", tag, bus.div_by_zero, (b == 0));
    end
`endif
    last_q = e[31:16];
    last_r = e[15:0];
  endtask

  task automatic test_reset;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Quotient !== 16'h0 ||
        bus.Remainder !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b q=%h r=%h required all zero",
               bus.busy, bus.done, bus.Quotient, bus.Remainder);
    end
`ifdef SEQ_DIV_DZ_EN
    checks++;
    if (bus.div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_dz: got %b required 0", bus.div_by_zero);
    end
`endif
    last_q = 16'h0;
    last_r = 16'h0;
  endtask

  task automatic test_basic;
    run_one(16'd100, 16'd7, 0, "div_100_7");
  endtask

  task automatic test_back_to_back;
    bus.start = 1'b1; bus.operand1 = 16'hFFFF; bus.operand2 = 16'd1;
    tick();
    bus.operand1 = 16'd5; bus.operand2 = 16'd9;
    for (int k = 1; k <= 16; k++) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.Quotient !== 16'hFFFF || bus.Remainder !== 16'h0) begin
      failures++;
      $display("FAIL b2b_first: done=%b q=%h r=%h required done=1 q=ffff r=0000",
               bus.done, bus.Quotient, bus.Remainder);
    end
    tick();
    bus.start = 1'b0;
    bus.operand1 = 16'($urandom); bus.operand2 = 16'($urandom);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.Quotient !== 16'hFFFF) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b done=%b q=%h required busy=1 done=0 q=ffff",
               bus.busy, bus.done, bus.Quotient);
    end
    for (int k = 18; k <= 33; k++) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.Quotient !== 16'h0 || bus.Remainder !== 16'd5) begin
      failures++;
      $display("FAIL b2b_second: done=%b q=%h r=%h required done=1 q=0000 r=0005",
               bus.done, bus.Quotient, bus.Remainder);
    end
    last_q = 16'h0;
    last_r = 16'd5;
  endtask

  task automatic test_div_zero;
    run_one(16'h1234, 16'h0, 0, "div_by_zero");
  endtask

  task automatic test_ignore_start;
    run_one(16'd1000, 16'd10, 5, "ignore_start");
  endtask

  task automatic test_reset_mid_run;
    bus.start = 1'b1; bus.operand1 = 16'd4321; bus.operand2 = 16'd17;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Quotient !== 16'h0 ||
        bus.Remainder !== 16'h0) begin
      failures++;
      $display("FAIL mid_run_reset: busy=%b done=%b q=%h r=%h required all zero",
               bus.busy, bus.done, bus.Quotient, bus.Remainder);
    end
`ifdef SEQ_DIV_DZ_EN
    checks++;
    if (bus.div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL mid_run_reset_dz: got %b required 0", bus.div_by_zero);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    last_q = 16'h0;
    last_r = 16'h0;
    run_one(16'd50, 16'd3, 0, "after_reset_50_3");
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    logic [31:0] e;
    int n, lat;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 16'h0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'hFFFF - 16'($urandom_range(0, 255));
        default: b = 16'($urandom);
      endcase
      a = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom);
      exp_q.push_back(model(a, b));
      lat = (DZ_EN && b == 0) ? 0 : 16;
      bus.start = 1'b1; bus.operand1 = a; bus.operand2 = b;
      tick();
      bus.start = 1'b0;
      bus.operand1 = 16'($urandom); bus.operand2 = 16'($urandom);
      n = 0;
      while (bus.done !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      e = exp_q.pop_front();
      checks++;
      if (n != lat || bus.Quotient !== e[31:16] || bus.Remainder !== e[15:0]) begin
        failures++;
        $display("FAIL rand%0d %h/%h: edges=%0d q=%h r=%h required edges=%0d q=%h r=%h",
                 i, a, b, n, bus.Quotient, bus.Remainder, lat, e[31:16], e[15:0]);
      end
      checks++;
      if ((32'(bus.Quotient) * 32'(b) + 32'(bus.Remainder) != 32'(a) && b != 0) ||
          (b != 0 && bus.Remainder >= b)) begin
        failures++;
        $display("FAIL rand%0d identity %h/%h: q=%h r=%h required q*b+r=a and r<b",
                 i, a, b, bus.Quotient, bus.Remainder);
      end
    end
    last_q = bus.Quotient;
    last_r = bus.Remainder;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.operand1 = 16'h0;
    bus.operand2 = 16'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
